// File: rtl/uart.sv
// Byte UART transceiver (8 data bits, LSB first, optional even parity when UART_PARITY_EN is defined, 1 stop bit).
// Latency: Tx starts on the first tx tick after the send edge; LEDR/check_parity update at the receiver's stop-bit sample.
// Backpressure: none; load and send are ignored while the transmitter is busy, and the receiver rearms right after its stop sample.
`timescale 1ns/1ps
module uart #(
    parameter int counter_ceil_tr  = 2604,
    parameter int counter_ceil_rec = 2604
) (
    input  logic       CLOCK_125_p,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    input  logic       Rx,
    output logic       Tx,
    output logic [7:0] LEDR,
    output logic       check_parity
);

    localparam int TW = $clog2(counter_ceil_tr + 1);
    localparam int RW = $clog2(counter_ceil_rec + 1);
    localparam logic [TW-1:0] TR_LAST = TW'(counter_ceil_tr - 1);
    localparam logic [RW-1:0] REC_LAST = RW'(counter_ceil_rec - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    logic rst;
    logic load;
    logic send;
    assign rst  = KEY[0];
    assign load = KEY[1];
    assign send = KEY[2];

    // ---------------- transmitter ----------------
    logic [TW-1:0] cnt_tr;
    logic          clock_for_Transmitter;
    logic          clk_tr_q;
    logic          tx_tick;
    tx_state_t     tx_state, tx_state_nxt;
    logic          tx_nxt;
    logic [7:0]    tx_data;
    logic [7:0]    tx_shift;
    logic [2:0]    tx_bit_cnt;
    logic          pending;
    logic          key2_q;
    logic          send_edge;

    assign tx_tick   = clock_for_Transmitter & ~clk_tr_q;
    assign send_edge = send & ~key2_q;

    always_ff @(posedge CLOCK_125_p) begin
        if (rst) begin
            cnt_tr                <= '0;
            clock_for_Transmitter <= 1'b0;
            clk_tr_q              <= 1'b0;
        end else begin
            clk_tr_q <= clock_for_Transmitter;
            if (cnt_tr == TR_LAST) begin
                cnt_tr                <= '0;
                clock_for_Transmitter <= ~clock_for_Transmitter;
            end else begin
                cnt_tr <= cnt_tr + TW'(1);
            end
        end
    end

    // Tx is registered from tx_nxt, so the line level always reflects the state being entered.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_nxt       = Tx;
        if (tx_tick) begin
            case (tx_state)
                TX_IDLE: begin
                    if (pending) begin
                        tx_state_nxt = TX_START;
                        tx_nxt       = 1'b0;
                    end
                end
                TX_START: begin
                    tx_state_nxt = TX_DATA;
                    tx_nxt       = tx_data[0];
                end
                TX_DATA: begin
                    if (tx_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_nxt = TX_PARITY;
                        tx_nxt       = ^tx_data;
`else
                        tx_state_nxt = TX_STOP;
                        tx_nxt       = 1'b1;
`endif
                    end else begin
                        tx_nxt = tx_shift[0];
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    tx_state_nxt = TX_STOP;
                    tx_nxt       = 1'b1;
                end
`endif
                TX_STOP: begin
                    tx_state_nxt = TX_IDLE;
                    tx_nxt       = 1'b1;
                end
                default: begin
                    tx_state_nxt = TX_IDLE;
                    tx_nxt       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_125_p) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            Tx         <= 1'b1;
            tx_data    <= 8'h00;
            tx_shift   <= 8'h00;
            tx_bit_cnt <= 3'd0;
            pending    <= 1'b0;
            key2_q     <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            Tx       <= tx_nxt;
            key2_q   <= send;
            if (load && tx_state == TX_IDLE)
                tx_data <= SW;
            if (tx_tick && tx_state == TX_IDLE && pending)
                pending <= 1'b0;
            else if (send_edge && tx_state == TX_IDLE)
                pending <= 1'b1;
            // tx_data is frozen once busy, so parity can be taken from it directly.
            if (tx_tick && tx_state == TX_START) begin
                tx_shift   <= {1'b0, tx_data[7:1]};
                tx_bit_cnt <= 3'd0;
            end else if (tx_tick && tx_state == TX_DATA) begin
                tx_shift   <= {1'b0, tx_shift[7:1]};
                tx_bit_cnt <= tx_bit_cnt + 3'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_fall;
    logic          rx_restart;
    logic [RW-1:0] cnt_rec;
    logic          clock_for_Receiver;
    logic          rx_tick;
    rx_state_t     rx_state, rx_state_nxt;
    logic [7:0]    rx_shift;
    logic [2:0]    rx_bit_cnt;
`ifdef UART_PARITY_EN
    logic          rx_par;
`endif

    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_restart = (rx_state == RX_IDLE) && rx_fall;
    // Receiver clock is re-phased on the start edge, so each rising edge lands mid-bit.
    assign rx_tick    = (cnt_rec == REC_LAST) && !clock_for_Receiver;

    always_ff @(posedge CLOCK_125_p) begin
        if (rst) begin
            rx_s1              <= 1'b1;
            rx_s2              <= 1'b1;
            rx_prev            <= 1'b1;
            cnt_rec            <= '0;
            clock_for_Receiver <= 1'b0;
        end else begin
            rx_s1   <= Rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_restart) begin
                cnt_rec            <= '0;
                clock_for_Receiver <= 1'b0;
            end else if (cnt_rec == REC_LAST) begin
                cnt_rec            <= '0;
                clock_for_Receiver <= ~clock_for_Receiver;
            end else begin
                cnt_rec <= cnt_rec + RW'(1);
            end
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
            RX_START: if (rx_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_tick && rx_bit_cnt == 3'd7)
`ifdef UART_PARITY_EN
                    rx_state_nxt = RX_PARITY;
`else
                    rx_state_nxt = RX_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (rx_tick) rx_state_nxt = RX_STOP;
`endif
            RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_125_p) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            rx_shift     <= 8'h00;
            rx_bit_cnt   <= 3'd0;
            LEDR         <= 8'h00;
            check_parity <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par       <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_tick) begin
                case (rx_state)
                    RX_START: rx_bit_cnt <= 3'd0;
                    RX_DATA: begin
                        rx_shift   <= {rx_s2, rx_shift[7:1]};
                        rx_bit_cnt <= rx_bit_cnt + 3'd1;
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: rx_par <= rx_s2;
`endif
                    RX_STOP: begin
                        LEDR <= rx_shift;
`ifdef UART_PARITY_EN
                        check_parity <= rx_s2 & ~(rx_par ^ (^rx_shift));
`else
                        check_parity <= rx_s2;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: stimulus queues expected Tx frames and receive results, line monitors decode and compare.
`timescale 1ns/1ps
module tb_uart;
    localparam int CEIL = 4;
    localparam int BIT  = 2 * CEIL;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] FR_B3 = 11'b111_0110_0110;
    localparam logic [10:0] FR_00 = 11'b100_0000_0000;
    localparam logic        CP_BADPAR = 1'b0;
`else
    localparam int NB = 10;
    localparam logic [10:0] FR_B3 = 11'b011_0110_0110;
    localparam logic [10:0] FR_00 = 11'b010_0000_0000;
    localparam logic        CP_BADPAR = 1'b1;
`endif
    // 0x5A with wrong parity bit (or plain stop=1 without parity), and with a zero stop bit
    localparam logic [10:0] FR_5A_BADPAR = 11'b110_1011_0100;
    localparam logic [10:0] FR_5A_STOP0  = 11'b000_1011_0100;

    logic       clk = 1'b0;
    logic [2:0] KEY;
    logic [7:0] SW;
    logic       rx_drv;
    logic       loop_en;
    logic       rx_line;
    logic       Tx;
    logic [7:0] LEDR;
    logic       check_parity;

    int  checks = 0;
    int  errors = 0;
    bit  discard = 1'b0;
    logic [10:0] tx_q[$];
    logic [8:0]  rx_q[$];

    assign rx_line = loop_en ? Tx : rx_drv;
    always #5 clk = ~clk;

    uart #(.counter_ceil_tr(CEIL), .counter_ceil_rec(CEIL)) dut (
        .CLOCK_125_p (clk),
        .KEY         (KEY),
        .SW          (SW),
        .Rx          (rx_line),
        .Tx          (Tx),
        .LEDR        (LEDR),
        .check_parity(check_parity)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input logic [10:0] f);
        for (int i = 0; i < NB; i++) begin
            rx_drv = f[i];
            clks(BIT);
        end
        rx_drv = 1'b1;
    endtask

    function automatic logic [10:0] mask_frame(input logic [10:0] f);
        logic [10:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) m[i] = f[i];
        return m;
    endfunction

    // Tx monitor: decode each frame at bit centres and compare against the queued frame.
    initial begin : tx_mon
        logic        prev;
        logic [10:0] got;
        logic [10:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && Tx === 1'b0) begin
                got = '0;
                repeat (CEIL) @(negedge clk);
                for (int i = 0; i < NB; i++) begin
                    got[i] = Tx;
                    if (i < NB - 1) repeat (BIT) @(negedge clk);
                end
                if (!discard) begin
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_frame: unexpected frame 0x%0h", got);
                    end else begin
                        exp = tx_q.pop_front();
                        check("tx_frame", got, mask_frame(exp));
                    end
                end
            end
            prev = Tx;
        end
    end

    // Rx monitor: follow each real frame on the receive line, then compare LEDR/check_parity.
    initial begin : rx_mon
        logic       prev;
        logic [8:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && rx_line === 1'b0) begin
                repeat (CEIL) @(negedge clk);
                if (rx_line === 1'b0) begin
                    repeat (BIT * (NB - 1) + 6) @(negedge clk);
                    if (!discard) begin
                        if (rx_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_result: unexpected LEDR 0x%0h", LEDR);
                        end else begin
                            exp = rx_q.pop_front();
                            check("rx_ledr", LEDR, exp[7:0]);
                            check("rx_parity", check_parity, exp[8]);
                        end
                    end
                end
            end
            prev = rx_line;
        end
    end

    initial begin : stim
        int n;
        KEY = 3'b001; SW = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
        clks(2);
        check("reset_tx", Tx, 1);
        check("reset_ledr", LEDR, 8'h00);
        check("reset_cp", check_parity, 0);
        KEY = 3'b000;
        clks(5);

        // Loopback 0xB3: load for two tx ticks, then send for two tx ticks.
        loop_en = 1'b1; SW = 8'hB3;
        tx_q.push_back(FR_B3); rx_q.push_back({1'b1, 8'hB3});
        KEY[1] = 1'b1; clks(2 * BIT); KEY[1] = 1'b0;
        KEY[2] = 1'b1; clks(2 * BIT); KEY[2] = 1'b0;
        clks(NB * BIT + 30);

        // Byte 0x00 with send held for three frames and SW changed mid-frame under load.
        SW = 8'h00;
        tx_q.push_back(FR_00); rx_q.push_back({1'b1, 8'h00});
        KEY[1] = 1'b1; clks(2 * BIT); KEY[1] = 1'b0;
        KEY[2] = 1'b1; clks(40);
        SW = 8'hFF; KEY[1] = 1'b1; clks(16); KEY[1] = 1'b0;
        clks(3 * NB * BIT - 56);
        KEY[2] = 1'b0;
        clks(30);

        // Externally driven frames.
        loop_en = 1'b0;
        rx_q.push_back({CP_BADPAR, 8'h5A});
        drive_rx(FR_5A_BADPAR); clks(30);
        rx_q.push_back({1'b0, 8'h5A});
        drive_rx(FR_5A_STOP0); clks(30);

        // One-clock glitch on idle line must be rejected.
        rx_drv = 1'b0; clks(1); rx_drv = 1'b1;
        clks(40);
        check("glitch_ledr", LEDR, 8'h5A);
        check("glitch_cp", check_parity, 0);

        // Send latency, then reset during a zero data bit.
        loop_en = 1'b1; SW = 8'hB3;
        KEY[1] = 1'b1; clks(2 * BIT); KEY[1] = 1'b0;
        KEY[2] = 1'b1;
        n = 0;
        while (Tx !== 1'b0 && n < 2 * CEIL + 2) begin
            clks(1);
            n++;
        end
        check("send_latency", Tx, 0);
        clks(28);
        check("pre_abort_tx", Tx, 0);
        discard = 1'b1;
        KEY = 3'b001;
        clks(1);
        check("abort_tx", Tx, 1);
        clks(10);
        check("abort_ledr", LEDR, 8'h00);
        check("abort_cp", check_parity, 0);
        KEY = 3'b000;
        clks(NB * BIT + 20);
        discard = 1'b0;
        clks(20);

        check("tx_queue_empty", tx_q.size(), 0);
        check("rx_queue_empty", rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
